// File: rtl/param_chan_pipe.sv
// param_chan_pipe: CHANNELS independent WIDTH-bit lanes, each combined with a
// fixed bitwise op (MODE) and carried through a DEPTH-stage valid/ready
// pipeline. Every stage can load whenever it is empty or draining, so the
// pipeline sustains one beat per cycle and keeps filling behind a stall.
// Optional: define PARAM_CHAN_PIPE_PARITY_EN to add out_par, the per-channel
// XOR reduction of out_y, registered together with out_y.
module param_chan_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_y,
  output logic [15:0]               xfer_cnt
`ifdef PARAM_CHAN_PIPE_PARITY_EN
  ,
  output logic [CHANNELS-1:0]       out_par
`endif
);

  localparam int CW = CHANNELS * WIDTH;

  logic [CW-1:0]            op_res;
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][CW-1:0] dat_q, dat_d;
  logic [DEPTH-1:0]         ld;
  logic [15:0]              xfer_q, xfer_d;

  // Per-channel op on the input slices; lanes never interact.
  always_comb begin
    op_res = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (MODE)
        0:       op_res[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] & in_b[k*WIDTH +: WIDTH];
        1:       op_res[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] | in_b[k*WIDTH +: WIDTH];
        2:       op_res[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] ^ in_b[k*WIDTH +: WIDTH];
        default: op_res[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH];
      endcase
    end
  end

  // Load enables ripple back from the output: a stage loads when it is empty
  // or the stage after it (or the consumer) takes its contents this cycle.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    ld  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ld[i] = !vld_q[i] || nxt;
      nxt   = ld[i];
    end
  end

  // in_ready depends only on stage state and out_ready, never on in_valid.
  assign in_ready = rst_n && ld[0];

  // Next-state for the stage valids and data.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (ld[0]) begin
      vld_d[0] = in_valid;
      dat_d[0] = op_res;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (ld[i]) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // Output transfer counter, saturating at all-ones.
  always_comb begin
    xfer_d = xfer_q;
    if (out_valid && out_ready && (xfer_q != 16'hFFFF)) xfer_d = xfer_q + 16'd1;
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      dat_q  <= '0;
      xfer_q <= '0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      xfer_q <= xfer_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_y     = dat_q[DEPTH-1];
  assign xfer_cnt  = xfer_q;

`ifdef PARAM_CHAN_PIPE_PARITY_EN
  logic [CHANNELS-1:0] par_q, par_d;

  // Parity of whatever the last stage will hold next, so it tracks out_y.
  always_comb begin
    par_d = '0;
    for (int k = 0; k < CHANNELS; k++) par_d[k] = ^dat_d[DEPTH-1][k*WIDTH +: WIDTH];
  end

  // Parity register, updated in lockstep with the last data stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= '0;
    else        par_q <= par_d;
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_param_chan_pipe.sv
// Directed bench for param_chan_pipe: handshake latency, ops, stall/hold,
// streaming throughput, mid-flight reset and counter saturation.
module tb_param_chan_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [15:0] in_a, in_b;

  logic        rdy0, vld0, rdy1, vld1, rdy2, vld2;
  logic [15:0] y0, y1, y2, cnt0, cnt1, cnt2;
`ifdef PARAM_CHAN_PIPE_PARITY_EN
  logic [3:0]  par0, par1, par2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // AND, depth 2
  param_chan_pipe #(.WIDTH(4), .CHANNELS(4), .DEPTH(2), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .out_valid(vld0), .out_ready(out_ready),
    .out_y(y0), .xfer_cnt(cnt0)
`ifdef PARAM_CHAN_PIPE_PARITY_EN
    , .out_par(par0)
`endif
  );

  // pass-through, depth 1
  param_chan_pipe #(.WIDTH(4), .CHANNELS(4), .DEPTH(1), .MODE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .out_valid(vld1), .out_ready(out_ready),
    .out_y(y1), .xfer_cnt(cnt1)
`ifdef PARAM_CHAN_PIPE_PARITY_EN
    , .out_par(par1)
`endif
  );

  // XOR, depth 2
  param_chan_pipe #(.WIDTH(4), .CHANNELS(4), .DEPTH(2), .MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .out_valid(vld2), .out_ready(out_ready),
    .out_y(y2), .xfer_cnt(cnt2)
`ifdef PARAM_CHAN_PIPE_PARITY_EN
    , .out_par(par2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n beats (value base+i, AND with FFFF) through u0 with out_ready
  // low for loop cycles st_lo..st_hi; checks order, in_ready and stall hold.
  task automatic run_stream(input int n, input int base, input int st_lo, input int st_hi,
                            input int budget, output int first, output int last,
                            output bit saw_low);
    logic [15:0] q[$];
    logic [15:0] prev_y;
    bit          prev_stall;
    int          sent, got;
    sent = 0; got = 0; first = -1; last = -1; saw_low = 0;
    prev_stall = 0; prev_y = '0;
    for (int c = 0; c < budget && got < n; c++) begin
      out_ready = !(c >= st_lo && c <= st_hi);
      in_valid  = (sent < n);
      in_a      = 16'(base + sent);
      in_b      = 16'hFFFF;
      #1;
      chk("in_ready_occ", rdy0, (q.size() < 2) || out_ready);
      if (in_valid && !rdy0) saw_low = 1;
      if (vld0 && !out_ready) begin
        if (prev_stall) chk("stall_hold", y0, prev_y);
        prev_y     = y0;
        prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
      if (vld0 && out_ready) begin
        chk("order", y0, (q.size() > 0) ? q[0] : 16'hDEAD);
        if (q.size() > 0) void'(q.pop_front());
        got++;
        if (first < 0) first = c;
        last = c;
      end
      if (in_valid && rdy0) begin
        q.push_back(16'(base + sent));
        sent++;
      end
      tick();
    end
    in_valid = 0;
    chk("all_out", got, n);
    chk("none_left", q.size(), 0);
  endtask

  initial begin
    int  first, last, m;
    bit  saw_low;

    rst_n = 0; in_valid = 0; out_ready = 1; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", vld0, 0);
    chk("rst_xfer_cnt", cnt0, 0);
    chk("rst_in_ready", rdy0, 0);
    chk("rst_out_y", y0, 0);
`ifdef PARAM_CHAN_PIPE_PARITY_EN
    chk("rst_par", par0, 0);
`endif

    // Single beat, MODE 0 latency and value.
    rst_n = 1; in_valid = 1; in_a = 16'hF0F0; in_b = 16'hFF00;
    #1;
    chk("ready_after_rst", rdy0, 1);
    tick();
    in_valid = 0;
    chk("lat_d2_early", vld0, 0);
    chk("d1_valid", vld1, 1);
    chk("d1_pass", y1, 16'hF0F0);
    tick();
    chk("lat_d2_valid", vld0, 1);
    chk("and_val", y0, 16'hF000);
    chk("xor_val0", y2, 16'h0FF0);
    chk("cnt_before", cnt0, 0);
    tick();
    chk("one_beat_only", vld0, 0);
    chk("cnt_one", cnt0, 1);
    chk("d1_cnt_one", cnt1, 1);

    // XOR mode and parity.
    in_valid = 1; in_a = 16'h1234; in_b = 16'h00FF;
    tick();
    in_valid = 0;
    tick();
    chk("xor_valid", vld2, 1);
    chk("xor_val", y2, 16'h12CB);
    chk("and_val2", y0, 16'h0034);
`ifdef PARAM_CHAN_PIPE_PARITY_EN
    chk("xor_par", par2, 4'b1101);
`endif
    tick();

    // Stall while streaming.
    run_stream(6, 1, 2, 5, 40, first, last, saw_low);
    chk("stall_in_ready_low", saw_low, 1);

    // Full-rate streaming.
    run_stream(10, 16'h40, -1, -1, 30, first, last, saw_low);
    chk("throughput", last - first, 9);
    chk("no_ready_drop", saw_low, 0);

    // Reset with two beats in flight.
    out_ready = 0; in_valid = 1; in_b = 16'hFFFF; in_a = 16'h0077;
    tick();
    in_a = 16'h0078;
    tick();
    in_valid = 0;
    chk("inflight_valid", vld0, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", vld0, 0);
    chk("mid_rst_cnt", cnt0, 0);
    chk("mid_rst_ready", rdy0, 0);
    chk("mid_rst_y", y0, 0);
    tick();
    rst_n = 1; out_ready = 1; in_valid = 1; in_a = 16'h005A;
    #1;
    tick();
    in_valid = 0;
    chk("post_rst_early", vld0, 0);
    tick();
    chk("post_rst_valid", vld0, 1);
    chk("post_rst_val", y0, 16'h005A);
    tick();

    // Saturation of the transfer counter.
    rst_n = 0;
    #1;
    tick();
    rst_n = 1; out_ready = 1; in_valid = 1; in_a = 16'h0003;
    #1;
    m = 0;
    for (int i = 0; i < 65545; i++) begin
      if (vld0 && out_ready) m++;
      tick();
      if (i == 1000) chk("cnt_mid", cnt0, 16'(m));
    end
    in_valid = 0;
    chk("cnt_sat", cnt0, 16'hFFFF);
    chk("cnt_sat_model", cnt0, (m > 65535) ? 16'hFFFF : 16'(m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
